// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one byte-oriented I2C master between NUM_REQ requesters.
// Each grant runs one transaction: issue, watch m_ready low time, report result via done.
module i2c_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                   i2c_clk_100k,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0]     req_rw,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             rdata,
    output logic                   nack,
    output logic                   timeout,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data_in,
    output logic                   m_rw,
    output logic                   m_enable,
    input  logic                   m_ready,
    input  logic [7:0]             m_data_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // A full acknowledged byte transfer keeps m_ready low for exactly this many cycles
    localparam logic [5:0] FULL_LOW  = 6'd20;
    localparam logic [5:0] ENA_DROP  = 6'd19;

    logic [1:0]    state_reg;
    logic [5:0]    lcnt_reg;
    logic [1:0]    issue_cnt_reg;
    logic [IW-1:0] owner_reg;
    logic [IW-1:0] last_grant_reg;

    logic [6:0]    addr_arr  [NUM_REQ];
    logic [7:0]    wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_arr[gi]  = req_addr[7*gi +: 7];
            assign wdata_arr[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

    // Round-robin search starting one past the previous owner
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    int            rr_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(last_grant_reg) + k) % NUM_REQ;
            if (!pick_valid && req[rr_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(rr_idx);
            end
        end
    end

    logic [6:0] lcnt_inc;
    logic [5:0] lcnt_sat;

    assign lcnt_inc = {1'b0, lcnt_reg} + 7'd1;
    assign lcnt_sat = lcnt_inc[6] ? 6'd63 : lcnt_inc[5:0];

    always_ff @(posedge i2c_clk_100k or posedge rst) begin
        if (rst) begin
            state_reg      <= ARB;
            lcnt_reg       <= '0;
            issue_cnt_reg  <= '0;
            owner_reg      <= '0;
            last_grant_reg <= IW'(NUM_REQ - 1);
            grant          <= '0;
            done           <= '0;
            rdata          <= '0;
            nack           <= 1'b0;
            timeout        <= 1'b0;
            m_addr         <= '0;
            m_data_in      <= '0;
            m_rw           <= 1'b0;
            m_enable       <= 1'b0;
        end else begin
            case (state_reg)
                ARB: begin
                    if (pick_valid && m_ready) begin
                        grant         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner_reg     <= pick_idx;
                        m_addr        <= addr_arr[pick_idx];
                        m_data_in     <= wdata_arr[pick_idx];
                        m_rw          <= req_rw[pick_idx];
                        m_enable      <= 1'b1;
                        rdata         <= '0;
                        nack          <= 1'b0;
                        timeout       <= 1'b0;
                        lcnt_reg      <= '0;
                        issue_cnt_reg <= '0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!m_ready) begin
                        lcnt_reg  <= 6'd1;
                        state_reg <= BUSY;
                    end else if (issue_cnt_reg == 2'd3) begin
                        m_enable  <= 1'b0;
                        timeout   <= 1'b1;
                        done      <= grant;
                        state_reg <= DONE;
                    end else begin
                        issue_cnt_reg <= issue_cnt_reg + 2'd1;
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        m_enable  <= 1'b0;
                        nack      <= (lcnt_reg != FULL_LOW);
                        if (m_rw && lcnt_reg == FULL_LOW)
                            rdata <= m_data_out;
                        done      <= grant;
                        state_reg <= DONE;
                    end else begin
                        lcnt_reg <= lcnt_sat;
                        // Drop enable before the master returns to idle so it does not restart
                        m_enable <= (lcnt_sat < ENA_DROP);
                        if (int'(lcnt_inc) >= TIMEOUT) begin
                            m_enable  <= 1'b0;
                            timeout   <= 1'b1;
                            nack      <= 1'b0;
                            done      <= grant;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    done           <= '0;
                    grant          <= '0;
                    last_grant_reg <= owner_reg;
                    state_reg      <= ARB;
                end
                default: state_reg <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: the bench plays the I2C master by driving m_ready low
// for a chosen number of cycles and checks grant order, outputs and timeouts.
module tb_i2c_master_arbiter;

    localparam int NUM_REQ = 4;

    logic                 i2c_clk_100k;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   req_rw;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           rdata;
    logic                 nack;
    logic                 timeout;
    logic [6:0]           m_addr;
    logic [7:0]           m_data_in;
    logic                 m_rw;
    logic                 m_enable;
    logic                 m_ready;
    logic [7:0]           m_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(40)) dut (
        .i2c_clk_100k (i2c_clk_100k),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rw       (req_rw),
        .grant        (grant),
        .done         (done),
        .rdata        (rdata),
        .nack         (nack),
        .timeout      (timeout),
        .m_addr       (m_addr),
        .m_data_in    (m_data_in),
        .m_rw         (m_rw),
        .m_enable     (m_enable),
        .m_ready      (m_ready),
        .m_data_out   (m_data_out)
    );

    initial i2c_clk_100k = 1'b0;
    always #5 i2c_clk_100k = ~i2c_clk_100k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
        req_addr[7*i +: 7]  = a;
        req_wdata[8*i +: 8] = d;
        req_rw[i]           = rw;
    endtask

    task automatic wait_enable(input string tag);
        int n;
        n = 0;
        while (n < 50 && m_enable !== 1'b1) begin
            @(negedge i2c_clk_100k);
            n++;
        end
        if (m_enable !== 1'b1) check({tag, "_enable_wait"}, 32'(m_enable), 32'd1);
    endtask

    // Hold m_ready low for n DUT samples, checking the enable drop point on long transfers
    task automatic slave_low(input int n, input logic [7:0] dout);
        m_ready = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge i2c_clk_100k);
            if (k == 18) check("enable_high_lcnt18", 32'(m_enable), 32'd1);
            if (k == 19) check("enable_low_lcnt19", 32'(m_enable), 32'd0);
        end
        m_data_out = dout;
        m_ready    = 1'b1;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (cycles < 100 && done === '0) begin
            @(negedge i2c_clk_100k);
            cycles++;
        end
        if (done === '0) check({tag, "_done_wait"}, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int order[3];

        rst        = 1'b1;
        req        = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rw     = '0;
        m_ready    = 1'b1;
        m_data_out = '0;
        repeat (3) @(negedge i2c_clk_100k);
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_enable", 32'(m_enable), 0);
        check("rst_addr", 32'(m_addr), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_nack_to", 32'({nack, timeout}), 0);
        rst = 1'b0;
        @(negedge i2c_clk_100k);

        // Single write to 0x50 on requester 1, slave acknowledges
        set_fields(1, 7'h50, 8'hA5, 1'b0);
        req = 4'b0010;
        wait_enable("wr");
        check("wr_grant", 32'(grant), 32'b0010);
        check("wr_addr", 32'(m_addr), 32'h50);
        check("wr_wdata", 32'(m_data_in), 32'hA5);
        check("wr_rw", 32'(m_rw), 0);
        slave_low(20, 8'h00);
        check("wr_no_restart_enable", 32'(m_enable), 0);
        wait_done("wr", cyc);
        check("wr_done_latency", 32'(cyc), 1);
        check("wr_done", 32'(done), 32'b0010);
        check("wr_nack", 32'(nack), 0);
        check("wr_timeout", 32'(timeout), 0);
        $display("txn write req1 addr=%0h nack=%0b timeout=%0b", m_addr, nack, timeout);
        req = '0;
        repeat (3) @(negedge i2c_clk_100k);
        check("wr_idle_enable", 32'(m_enable), 0);
        check("wr_idle_grant", 32'(grant), 0);
        check("wr_idle_done", 32'(done), 0);

        // Single read from 0x3C on requester 0
        set_fields(0, 7'h3C, 8'h00, 1'b1);
        req = 4'b0001;
        wait_enable("rd");
        check("rd_grant", 32'(grant), 32'b0001);
        check("rd_addr", 32'(m_addr), 32'h3C);
        check("rd_rw", 32'(m_rw), 1);
        slave_low(20, 8'h7E);
        wait_done("rd", cyc);
        check("rd_done", 32'(done), 32'b0001);
        check("rd_rdata", 32'(rdata), 32'h7E);
        check("rd_nack", 32'(nack), 0);
        $display("txn read req0 rdata=%0h nack=%0b", rdata, nack);
        req = '0;
        m_data_out = '0;

        // Address NACK on requester 3: master gives up after 11 low cycles
        set_fields(3, 7'h22, 8'h00, 1'b1);
        req = 4'b1000;
        wait_enable("nk");
        check("nk_grant", 32'(grant), 32'b1000);
        slave_low(11, 8'h55);
        wait_done("nk", cyc);
        check("nk_done", 32'(done), 32'b1000);
        check("nk_nack", 32'(nack), 1);
        check("nk_rdata", 32'(rdata), 0);
        check("nk_timeout", 32'(timeout), 0);
        $display("txn nack req3 nack=%0b rdata=%0h", nack, rdata);
        req = '0;
        m_data_out = '0;

        // Contention: all four request, each served once in order 0..3
        for (int i = 0; i < NUM_REQ; i++) set_fields(i, 7'(7'h10 + i), 8'(8'hC0 + i), 1'b0);
        req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_enable("cont");
            check("cont_grant", 32'(grant), 32'(1) << i);
            check("cont_addr", 32'(m_addr), 32'(7'h10 + i));
            slave_low(20, 8'h00);
            wait_done("cont", cyc);
            check("cont_done", 32'(done), 32'(1) << i);
            $display("txn contention grant=%b addr=%0h", grant, m_addr);
            req[i] = 1'b0;
        end

        // Requesters 1 and 3: requester 1 keeps requesting after its first done
        order[0] = 1; order[1] = 3; order[2] = 1;
        req = 4'b1010;
        for (int j = 0; j < 3; j++) begin
            wait_enable("rr");
            check("rr_grant", 32'(grant), 32'(1) << order[j]);
            slave_low(20, 8'h00);
            wait_done("rr", cyc);
            check("rr_done", 32'(done), 32'(1) << order[j]);
            $display("txn rr grant=%b", grant);
            if (j == 1) req[3] = 1'b0;
            if (j == 2) req[1] = 1'b0;
        end

        // Timeout with m_ready stuck low on requester 2
        req = 4'b0100;
        wait_enable("tl");
        check("tl_grant", 32'(grant), 32'b0100);
        m_ready = 1'b0;
        wait_done("tl", cyc);
        check("tl_cycles", 32'(cyc), 40);
        check("tl_done", 32'(done), 32'b0100);
        check("tl_timeout", 32'(timeout), 1);
        check("tl_nack", 32'(nack), 0);
        check("tl_enable", 32'(m_enable), 0);
        $display("txn timeout-low req2 cycles=%0d timeout=%0b", cyc, timeout);
        req = '0;
        m_ready = 1'b1;

        // Timeout with m_ready stuck high on requester 0
        req = 4'b0001;
        wait_enable("th");
        wait_done("th", cyc);
        check("th_cycles", 32'(cyc), 4);
        check("th_done", 32'(done), 32'b0001);
        check("th_timeout", 32'(timeout), 1);
        check("th_nack", 32'(nack), 0);
        $display("txn timeout-high req0 cycles=%0d timeout=%0b", cyc, timeout);
        req = '0;

        // Reset in BUSY at lcnt=10, then all-request must start at requester 0
        req = 4'b0010;
        wait_enable("mr");
        m_ready = 1'b0;
        repeat (10) @(negedge i2c_clk_100k);
        rst = 1'b1;
        #1;
        check("mr_grant", 32'(grant), 0);
        check("mr_enable", 32'(m_enable), 0);
        check("mr_outs", 32'({m_addr, m_data_in, m_rw, rdata, nack, timeout}), 0);
        repeat (2) @(negedge i2c_clk_100k);
        check("mr_done", 32'(done), 0);
        m_ready = 1'b1;
        req = 4'b1111;
        rst = 1'b0;
        wait_enable("mr");
        check("mr_first_grant", 32'(grant), 32'b0001);
        $display("txn after reset grant=%b", grant);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 40, max cycles allowed with m_ready low.
REQ-003 SHALL have port i2c_clk_100k  in  1  clock; reset rst, asynchronous, active-high; clock i2c_clk_100k.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port req  in  NUM_REQ  per-requester transaction request, level.
REQ-006 SHALL have port req_addr  in  7*NUM_REQ  7-bit slave address per requester, slice i at [7i+6:7i].
REQ-007 SHALL have port req_wdata  in  8*NUM_REQ  write byte per requester.
REQ-008 SHALL have port req_rw  in  NUM_REQ  1=read, 0=write.
REQ-009 SHALL have port grant  out  NUM_REQ  one-hot owner of current transaction.
REQ-010 SHALL have port done  out  NUM_REQ  one-cycle completion pulse to owner.
REQ-011 SHALL have port rdata  out  8  read byte, valid with done.
REQ-012 SHALL have port nack  out  1  slave did not acknowledge, valid with done.
REQ-013 SHALL have port timeout  out  1  transaction aborted on timeout, valid with done.
REQ-014 SHALL have port m_addr / m_data_in / m_rw / m_enable  out  7/8/1/1  drive I2C master inputs.
REQ-015 SHALL have port m_ready / m_data_out  in  1/8  from I2C master.

Function
REQ-016 SHALL implement FSM states ARB, ISSUE, BUSY, DONE; all transitions on posedge i2c_clk_100k.
REQ-017 ARB: if any req bit set and m_ready=1, SHALL grant one requester by round-robin starting at index (last_grant+1) mod NUM_REQ; latch its addr/wdata/rw into m_addr/m_data_in/m_rw; go ISSUE.
REQ-018 After reset, last_grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-019 ISSUE: SHALL assert m_enable; on first cycle m_ready sampled 0, go BUSY with low-cycle counter lcnt=1; if m_ready stays 1 for 4 cycles, SHALL set timeout and go DONE.
REQ-020 BUSY: lcnt SHALL increment each cycle m_ready=0 (saturating at 63).
REQ-021 BUSY: m_enable SHALL stay 1 while lcnt<19 and SHALL be 0 from lcnt=19, so the master's second-ack sample sees enable high and its return to IDLE sees enable low (no restart).
REQ-022 BUSY: on first cycle m_ready sampled 1, SHALL go DONE; nack SHALL be 1 iff total low cycles != 20; rdata SHALL capture m_data_out when m_rw=1 and nack=0, else hold 0.
REQ-023 BUSY: if lcnt reaches TIMEOUT with m_ready still 0, SHALL deassert m_enable, set timeout=1, nack=0, go DONE.
REQ-024 DONE: SHALL pulse done[owner] for exactly one cycle with rdata/nack/timeout valid, clear grant, update last_grant, go ARB.
REQ-025 grant SHALL stay constant from ARB exit to DONE; req changes after grant SHALL not affect the transaction.
REQ-026 A req bit deasserted before grant SHALL be ignored; requester holds req until its done pulse and SHALL drop it the cycle after done, else it re-enters arbitration.
REQ-027 Minimum gap between done of one transaction and m_enable of the next SHALL be 2 cycles (DONE, ARB).
REQ-028 Simultaneous requests SHALL each be served once before any requester is served twice.

Reset
REQ-029 On rst=1, regardless of state, SHALL go ARB immediately; grant, done, m_enable, m_addr, m_data_in, m_rw, rdata, nack, timeout SHALL be 0; lcnt=0; last_grant=NUM_REQ-1.
REQ-030 Reset mid-transaction SHALL produce no done pulse; first grant after release follows REQ-018.

Verification
REQ-031 Single write: req[1]=1, addr=0x50, wdata=0xA5, rw=0, slave ACKs -> grant=0010, m_addr=0x50, m_data_in=0xA5, m_ready low 20 cycles, done[1] pulse, nack=0, timeout=0, master does not restart.
REQ-032 Single read: req[0], addr=0x3C, rw=1, slave returns 0x7E -> done[0] with rdata=0x7E, nack=0.
REQ-033 Address NACK: slave silent -> m_ready low 11 cycles, done with nack=1, rdata=0x00.
REQ-034 Contention: req=1111 held, each dropped after its done -> grant order 0,1,2,3; with req=1010 after grant 1 -> next grant 3, then 1.
REQ-035 Timeout: m_ready forced low -> at lcnt=40 m_enable=0, done with timeout=1; m_ready stuck high -> done with timeout=1 after 4 ISSUE cycles.
REQ-036 Reset mid-BUSY (lcnt=10): all outputs 0 next edge, no done; subsequent req=1111 grants requester 0 first.
